// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver with a first-word-fall-through scancode FIFO.
// Frames: start(0), 8 data bits LSB first, odd parity, stop(1).
// Optional build macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd
// parity are dropped with a frame_err pulse; otherwise parity is ignored.
module ps2_receiver #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_rd_en,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overflow,
  output logic       o_frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchroniser and edge-detect flops; reset high to match an idle bus
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;

  state_e        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shreg;
  logic [TW-1:0] r_tcnt;
  logic          r_frame_err;
`ifdef PS2_PARITY_CHECK_EN
  logic          r_parity;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [7:0]    r_data;
  logic          r_overflow;

  logic          w_fall;
  logic          w_frame_ok;
  logic          w_push;
  logic          w_full, w_empty, w_pop, w_wr, w_drop;
  logic [PW-1:0] w_wptr_nx, w_rptr_nx;
  logic [7:0]    w_head_nx;

  assign w_fall = r_clk_prev & ~r_clk_s2;

`ifdef PS2_PARITY_CHECK_EN
  assign w_frame_ok = r_dat_s2 & (^{r_shreg, r_parity});
`else
  assign w_frame_ok = r_dat_s2;
`endif

  assign w_push = (r_state == StStop) && w_fall && w_frame_ok;

  // Two-flop synchronisers plus previous-value flop for falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= i_ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  // Frame FSM with inter-edge timeout; frame_err is a registered one-cycle pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_tcnt      <= '0;
      r_frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      if (r_state == StIdle) begin
        r_tcnt <= '0;
        // A sampled 1 here is a glitch and is silently ignored
        if (w_fall && !r_dat_s2) begin
          r_state   <= StData;
          r_bit_cnt <= '0;
        end
      end else if (w_fall) begin
        r_tcnt <= '0;
        case (r_state)
          StData: begin
            r_shreg   <= {r_dat_s2, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= StParity;
          end
          StParity: begin
`ifdef PS2_PARITY_CHECK_EN
            r_parity <= r_dat_s2;
`endif
            r_state <= StStop;
          end
          StStop: begin
            r_state     <= StIdle;
            r_frame_err <= ~w_frame_ok;
          end
          default: r_state <= StIdle;
        endcase
      end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
        r_state     <= StIdle;
        r_frame_err <= 1'b1;
        r_tcnt      <= '0;
      end else begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_rd_en & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  assign w_wptr_nx = r_wptr + {{AW{1'b0}}, w_wr};
  assign w_rptr_nx = r_rptr + {{AW{1'b0}}, w_pop};
  // New head is the byte being written when it lands exactly at the next read slot
  assign w_head_nx = (w_wr && (w_rptr_nx == r_wptr)) ? r_shreg : r_mem[w_rptr_nx[AW-1:0]];

  // FIFO storage (no reset needed; pointers define occupancy)
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shreg;
  end

  // Pointers, registered head byte (holds last value when empty) and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr <= w_wptr_nx;
      r_rptr <= w_rptr_nx;
      if (w_wptr_nx != w_rptr_nx) r_data <= w_head_nx;
      if (w_pop)       r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_data      = r_data;
  assign o_valid     = ~w_empty;
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed scenarios plus randomized
// frames, compared against a queue-based reference model of received bytes.
module tb_ps2_receiver;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 300;
  localparam int          HALF  = 400;  // PS/2 half period in ns (40 clk cycles)

  logic       clk = 1'b0;
  logic       rst;
  logic       i_ps2_clk, i_ps2_data, i_rd_en;
  logic [7:0] o_data;
  logic       o_valid, o_overflow, o_frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_ovf  = 1'b0;
  int         exp_err = 0;

  // Observed frame_err pulses
  int ferr_cnt = 0;
  int ferr_run = 0;
  int ferr_max = 0;

  ps2_receiver #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ps2_clk  (i_ps2_clk),
    .i_ps2_data (i_ps2_data),
    .i_rd_en    (i_rd_en),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_overflow (o_overflow),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_frame_err === 1'b1) begin
      ferr_cnt++;
      ferr_run++;
      if (ferr_run > ferr_max) ferr_max = ferr_run;
    end else begin
      ferr_run = 0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic perr,
                                             input logic stop);
    logic par;
    par = ~(^b) ^ perr;
    return {stop, par, b, 1'b0};
  endfunction

  // Drive the first n bits of a frame, LSB (start bit) first
  task automatic send_bits(input logic [10:0] bits, input int n);
    @(negedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      i_ps2_data = bits[i];
      #(HALF / 2);
      i_ps2_clk = 1'b0;
      #(HALF);
      i_ps2_clk = 1'b1;
      #(HALF / 2);
    end
    i_ps2_data = 1'b1;
  endtask

  // Reference model: a frame is accepted iff stop is 1 (and parity odd when checked)
  task automatic model_frame(input logic [7:0] b, input logic perr, input logic stop);
    logic good;
    good = stop;
`ifdef PS2_PARITY_CHECK_EN
    if (perr) good = 1'b0;
`endif
    if (!good) exp_err++;
    else if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
    if (q.size() > 0) m_data = q[0];
  endtask

  task automatic send_frame(input logic [7:0] b, input logic perr, input logic stop);
    send_bits(frame_bits(b, perr, stop), 11);
    model_frame(b, perr, stop);
    repeat (10) @(posedge clk);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    #1;
    check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, q.size() > 0});
    check({tag, ".data"}, {24'd0, o_data}, {24'd0, m_data});
    check({tag, ".ovf"}, {31'd0, o_overflow}, {31'd0, m_ovf});
    check({tag, ".ferr"}, ferr_cnt, exp_err);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    check({tag, ".head"}, {24'd0, o_data}, {24'd0, q[0]});
    i_rd_en = 1'b1;
    @(posedge clk);
    void'(q.pop_front());
    m_ovf = 1'b0;
    if (q.size() > 0) m_data = q[0];
    #1;
    i_rd_en = 1'b0;
    check_state({tag, ".after"});
  endtask

  initial begin
    int lat;
    logic [7:0] b;
    logic perr, stop;

    i_ps2_clk  = 1'b1;
    i_ps2_data = 1'b1;
    i_rd_en    = 1'b0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    check_state("reset");
    rst = 1'b0;

    // Pop on empty FIFO is ignored
    @(negedge clk);
    i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_en = 1'b0;
    check_state("empty_pop");

    // Single frame 0x1C with latency from the stop-bit pin fall
    send_bits(frame_bits(8'h1C, 1'b0, 1'b1), 10);
    i_ps2_data = 1'b1;
    #(HALF / 2);
    i_ps2_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (o_valid === 1'b1 && lat == 0) lat = k;
    end
    check("single.lat_ok", {31'd0, (lat >= 3 && lat <= 4)}, 32'd1);
    #(HALF);
    i_ps2_clk = 1'b1;
    #(HALF / 2);
    model_frame(8'h1C, 1'b0, 1'b1);
    check_state("single");
    pop_check("single_pop");

    // Burst ordering
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_state("burst");
    while (q.size() > 0) pop_check("burst_pop");

    // Overflow: DEPTH+1 frames without reads
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1);
    check_state("ovf");
    while (q.size() > 0) pop_check("ovf_pop");

    // Bad stop bit, then a good frame
    send_frame(8'h1C, 1'b0, 1'b0);
    check_state("badstop");
    send_frame(8'h29, 1'b0, 1'b1);
    check_state("after_badstop");
    pop_check("after_badstop_pop");

    // Parity error: dropped only when parity checking is built in
    send_frame(8'h1C, 1'b1, 1'b1);
    check_state("parity");
    while (q.size() > 0) pop_check("parity_pop");

    // Timeout after start + 4 data bits
    send_bits(frame_bits(8'hA5, 1'b0, 1'b1), 5);
    repeat (TMO - 100) @(posedge clk);
    check_state("tmo_early");
    repeat (100) @(posedge clk);
    exp_err++;
    check_state("tmo");
    send_frame(8'h3C, 1'b0, 1'b1);
    check_state("after_tmo");

    // Reset mid-frame with one byte buffered
    send_bits(frame_bits(8'h77, 1'b0, 1'b1), 4);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_data = 8'h00;
    m_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    check_state("midreset");
    rst = 1'b0;
    send_frame(8'h29, 1'b0, 1'b1);
    check_state("after_reset");
    pop_check("after_reset_pop");

    // Randomized frames with random reads
    for (int i = 0; i < 12; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      perr = ($urandom_range(0, 3) == 0);
      send_frame(b, perr, stop);
      check_state("rand");
      if (q.size() > 0 && $urandom_range(0, 1) == 1) pop_check("rand_pop");
    end
    while (q.size() > 0) pop_check("drain");
    check_state("final");
    check("ferr_width", ferr_max, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Upstream front end for `keyboard`. Deserialises PS/2 device-to-host frames from the keyboard connector into 8-bit scancodes and buffers them in a small first-word-fall-through FIFO. The head byte drives the 8-bit input of `keyboard`. The CPU-side strobe that makes `keyboard` latch a byte also pops it here.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, 2..64.
- `TIMEOUT`, default 5000: `clk` cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock from the pin; asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data from the pin; asynchronous to `clk`.
- `rd_en` in 1: pop the FIFO head.
- `data` out 8: FIFO head byte; holds the last value when the FIFO is empty.
- `valid` out 1: FIFO non-empty.
- `overflow` out 1: sticky; set when a byte is lost because the FIFO is full.
- `frame_err` out 1: one-cycle pulse on a dropped frame.

## Operation

- Synchronisation:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - A falling edge is the synced `ps2_clk` being 1 in the previous cycle and 0 in the current one.
  - All bit sampling uses synced `ps2_data` in the edge cycle.
- Frame format: start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
- FSM states are IDLE, DATA, PARITY and STOP. All transitions occur on a falling edge, except timeout.
  - IDLE: sampled 0 → DATA, bit counter cleared. Sampled 1 → stay in IDLE (glitch, no error).
  - DATA: shift the bit into `shreg[7]`, shifting right. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: sampled 1 with good parity → push `shreg` to the FIFO, then IDLE. Sampled 0 → `frame_err` pulse, nothing pushed, IDLE.
- Timeout:
  - A counter counts cycles since the last falling edge while the FSM is not IDLE.
  - On reaching `TIMEOUT` → IDLE, `frame_err` pulse, partial byte discarded.
  - The counter resets on every falling edge and whenever the FSM is in IDLE.
- FIFO:
  - Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits; the MSB distinguishes full from empty. Pointers wrap modulo 2×depth.
  - `rd_en` while `valid`=0 is ignored.
  - Push while full: the byte is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both take effect; no overflow.
  - Push and pop in the same cycle while the FIFO holds 1 entry: `valid` stays 1 and `data` shows the new byte.
  - `overflow` clears on the next accepted pop.
- Reset mid-frame: FSM to IDLE, FIFO emptied, partial byte lost.
- Reset values:
  - `data`=0x00, `valid`=0, `overflow`=0, `frame_err`=0.
  - FSM=IDLE, pointers=0, synchroniser flops=1.

## Timing

- Pin to edge detect: 3 `clk` cycles after a `ps2_clk` fall at the pin.
- Push occurs in the cycle after the stop-bit edge is detected. `valid` and `data` are updated on that same clock edge.
- Pop: `rd_en` sampled high at edge N. At N, `data` shows the next entry, or `valid` drops to 0 if that was the last entry.
- `frame_err` is high for exactly one cycle, the cycle after the detecting edge or timeout.
- `clk` must be ≥ 8× the PS/2 clock (10–16.7 kHz); there is no other constraint.

## Configuration

- Macro: `PS2_PARITY_CHECK_EN`.
- Defined: in STOP, the XOR of the 8 data bits and the parity bit must be 1. If not, the frame raises a `frame_err` pulse and is not pushed.
- Undefined: the parity bit is sampled and ignored. Only the stop bit qualifies the frame.

## Test plan

- Single frame: send 0x1C (parity 0, stop 1) at 12.5 kHz → `valid`=1 with `data`=0x1C one cycle after the stop edge. Pulse `rd_en` → `valid`=0.
- Burst ordering: send 0xF0, 0x1C, 0x5A → popped in that order. `overflow`=0 throughout.
- Overflow: send `FIFO_DEPTH`+1 frames with no reads → `overflow`=1 and the FIFO holds the first 8 bytes. The first pop returns the first byte and clears `overflow`.
- Bad stop bit: send 0x1C with stop 0 → one `frame_err` pulse, `valid` stays 0. A following good 0x29 is received correctly.
- Parity: send 0x1C with parity 1.
  - With `PS2_PARITY_CHECK_EN` → `frame_err` pulse, no push.
  - Without it → 0x1C is pushed.
- Timeout and reset: stop `ps2_clk` after 4 data bits → after `TIMEOUT` cycles, `frame_err` pulse and FSM back in IDLE; the next full frame is received. Separately, assert `rst` mid-frame → all outputs return to their reset values and the next frame is received cleanly.
